// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, transmit result codes, common
// keyboard command bytes and the odd-parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACKED,
    FAIL,
    DONE
  } ps2_tx_state_t;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_NO_ACK   = 2'd1,
    ERR_START_TO = 2'd2,
    ERR_PKT_TO   = 2'd3
  } tx_err_t;

  localparam logic [7:0] PS2_CMD_SETLED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_RSP_ACK    = 8'hFA;

  // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake between the requester and the PS/2 host transmitter.
interface ps2_host_tx_if;
  import ps2_pkg::*;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  tx_err_t    tx_err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, tx_done, tx_err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, tx_done, tx_err
  );

endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pads plus a one-cycle
// falling-edge pulse on the clock line. Idle bus level is high, so the
// flops reset to 1 to avoid a false edge when reset is released.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2clk_in,
  input  logic ps2data_in,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic clk_meta;
  logic clk_prev;
  logic data_meta;

  // Bring both pads into the clk domain and keep one extra clock-line stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2clk_in;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2data_in;
      data_sync <= data_meta;
    end
  end

  assign clk_fall = clk_prev & ~clk_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Pulls the clock low for a request-to-send,
// drives the start bit, then shifts the byte LSB-first, odd parity and stop
// on device-generated falling edges and finally checks the device ack bit.
// Line outputs are pull-low enables only; the pads are open drain at top level.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC  = 12000,
  parameter int START_TO_CYC = 1500000,
  parameter int PKT_TO_CYC   = 200000
) (
  input  logic          clk,
  input  logic          rst_n,
  ps2_host_tx_if.slave  bus,
  input  logic          ps2clk_in,
  input  logic          ps2data_in,
  output logic          ps2clk_low,
  output logic          ps2data_low
);

  localparam logic [20:0] INHIBIT_LAST = 21'(INHIBIT_CYC - 1);
  localparam logic [20:0] START_LIM    = 21'(START_TO_CYC);
  localparam logic [20:0] PKT_LIM      = 21'(PKT_TO_CYC);

  ps2_tx_state_t state;
  logic [20:0]   timer;
  logic [3:0]    fall_cnt;
  logic [7:0]    tx_byte;
  logic          parity;
  tx_err_t       fail_code;
  logic          tx_ready_q;
  logic          tx_done_q;
  tx_err_t       tx_err_q;

  logic clk_sync;
  logic data_sync;
  logic clk_fall;

  ps2_line_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2clk_in  (ps2clk_in),
    .ps2data_in (ps2data_in),
    .clk_sync   (clk_sync),
    .data_sync  (data_sync),
    .clk_fall   (clk_fall)
  );

  assign bus.tx_ready = tx_ready_q;
  assign bus.busy     = ~tx_ready_q;
  assign bus.tx_done  = tx_done_q;
  assign bus.tx_err   = tx_err_q;

  // Transfer sequencer: all outputs are registered and change on state transitions.
  // Falls are only acted on in REQ/SEND, so the edge the host itself makes during
  // INHIBIT is ignored. SEND and ACKED share one packet timer started at the first fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      fall_cnt    <= '0;
      tx_byte     <= '0;
      parity      <= 1'b0;
      fail_code   <= ERR_OK;
      tx_ready_q  <= 1'b1;
      tx_done_q   <= 1'b0;
      tx_err_q    <= ERR_OK;
      ps2clk_low  <= 1'b0;
      ps2data_low <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.tx_valid) begin
            tx_byte     <= bus.tx_data;
            parity      <= odd_parity(bus.tx_data);
            tx_err_q    <= ERR_OK;
            tx_ready_q  <= 1'b0;
            ps2clk_low  <= 1'b1;
            ps2data_low <= 1'b0;
            timer       <= '0;
            state       <= INHIBIT;
          end
        end

        INHIBIT: begin
          if (timer == INHIBIT_LAST) begin
            ps2clk_low  <= 1'b0;
            ps2data_low <= 1'b1;
            timer       <= '0;
            fall_cnt    <= '0;
            state       <= REQ;
          end else begin
            timer <= timer + 21'd1;
          end
        end

        REQ: begin
          if (clk_fall) begin
            ps2data_low <= ~tx_byte[0];
            fall_cnt    <= 4'd1;
            timer       <= '0;
            state       <= SEND;
          end else if (timer >= START_LIM) begin
            fail_code   <= ERR_START_TO;
            ps2data_low <= 1'b0;
            state       <= FAIL;
          end else begin
            timer <= timer + 21'd1;
          end
        end

        SEND: begin
          if (timer >= PKT_LIM) begin
            fail_code   <= ERR_PKT_TO;
            ps2data_low <= 1'b0;
            state       <= FAIL;
          end else begin
            timer <= timer + 21'd1;
            if (clk_fall) begin
              fall_cnt <= fall_cnt + 4'd1;
              case (fall_cnt)
                4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7:
                  ps2data_low <= ~tx_byte[fall_cnt[2:0]];
                4'd8:
                  ps2data_low <= ~parity;
                4'd9:
                  ps2data_low <= 1'b0;
                4'd10: begin
                  if (data_sync) begin
                    fail_code <= ERR_NO_ACK;
                    state     <= FAIL;
                  end else begin
                    state <= ACKED;
                  end
                end
                default: ;
              endcase
            end
          end
        end

        ACKED: begin
          if (timer >= PKT_LIM) begin
            fail_code <= ERR_PKT_TO;
            state     <= FAIL;
          end else if (clk_sync && data_sync) begin
            tx_done_q <= 1'b1;
            tx_err_q  <= ERR_OK;
            state     <= DONE;
          end else begin
            timer <= timer + 21'd1;
          end
        end

        FAIL: begin
          ps2clk_low  <= 1'b0;
          ps2data_low <= 1'b0;
          tx_done_q   <= 1'b1;
          tx_err_q    <= fail_code;
          state       <= DONE;
        end

        DONE: begin
          tx_ready_q <= 1'b1;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 keyboard model
// driving a 40-cycle device clock on a wired-AND bus.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  logic clk;
  logic rst_n;
  logic ps2clk_in;
  logic ps2data_in;
  logic ps2clk_low;
  logic ps2data_low;
  logic dev_clk;
  logic dev_data;

  int tests_run;
  int tests_failed;
  int done_count;
  logic [1:0] last_err;

  ps2_host_tx_if bus ();

  ps2_host_tx #(
    .INHIBIT_CYC  (20),
    .START_TO_CYC (400),
    .PKT_TO_CYC   (4000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .ps2clk_in   (ps2clk_in),
    .ps2data_in  (ps2data_in),
    .ps2clk_low  (ps2clk_low),
    .ps2data_low (ps2data_low)
  );

  // Open-drain bus: either side can pull a line low
  assign ps2clk_in  = dev_clk & ~ps2clk_low;
  assign ps2data_in = dev_data & ~ps2data_low;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every tx_done pulse and remember its error code
  always @(negedge clk) begin
    if (bus.tx_done === 1'b1) begin
      done_count = done_count + 1;
      last_err   = bus.tx_err;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] d);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  // Wait for the host to pull the clock low, then count how long it stays low
  task automatic wait_inhibit(output int n);
    int w;
    w = 0;
    while (ps2clk_low !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    n = 0;
    while (ps2clk_low === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Keyboard model: clock nfalls bits, sampling the data line just before each rising edge
  task automatic dev_frame(input int nfalls, input bit ack, output logic [10:0] bits);
    bits = '1;
    repeat (10) @(negedge clk);
    for (int i = 1; i <= nfalls; i++) begin
      if (i == 11) begin
        if (ack) dev_data = 1'b0;
        repeat (10) @(negedge clk);
      end
      dev_clk = 1'b0;
      repeat (20) @(negedge clk);
      bits[i-1] = ps2data_in;
      dev_clk = 1'b1;
      repeat (20) @(negedge clk);
    end
    dev_data = 1'b1;
  endtask

  task automatic wait_done(input int mark, input int bound, input string tag, output int n);
    n = 0;
    while (done_count == mark && n < bound) begin
      @(negedge clk);
      n++;
    end
    check_output(tag, done_count - mark, 1);
  endtask

  initial begin
    logic [10:0] bits;
    logic [7:0]  p_data [3];
    logic        p_par  [3];
    int n;
    int mark;

    tests_run    = 0;
    tests_failed = 0;
    done_count   = 0;
    last_err     = 2'd0;
    dev_clk      = 1'b1;
    dev_data     = 1'b1;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    rst_n        = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_output("rst_ready", bus.tx_ready, 1);
    check_output("rst_busy", bus.busy, 0);
    check_output("rst_done", bus.tx_done, 0);
    check_output("rst_err", bus.tx_err, 0);
    check_output("rst_clk_low", ps2clk_low, 0);
    check_output("rst_data_low", ps2data_low, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: set-LEDs command, full frame with ack
    $display("[TB] step 1: send 0xED");
    mark = done_count;
    apply_stimulus(PS2_CMD_SETLED);
    check_output("t1_busy", bus.busy, 1);
    wait_inhibit(n);
    check_output("t1_inhibit_len", n, 20);
    check_output("t1_start_bit", ps2data_low, 1);
    dev_frame(11, 1'b1, bits);
    check_output("t1_byte", bits[7:0], 8'hED);
    check_output("t1_parity", bits[8], 1);
    check_output("t1_stop", bits[9], 1);
    wait_done(mark, 200, "t1_done", n);
    check_output("t1_err", last_err, 0);
    @(negedge clk);
    check_output("t1_clk_rel", ps2clk_low, 0);
    check_output("t1_data_rel", ps2data_low, 0);
    check_output("t1_ready", bus.tx_ready, 1);

    // 2: parity corner bytes
    $display("[TB] step 2: parity patterns");
    p_data[0] = 8'h00; p_par[0] = 1'b1;
    p_data[1] = 8'hFF; p_par[1] = 1'b1;
    p_data[2] = 8'h01; p_par[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mark = done_count;
      apply_stimulus(p_data[i]);
      wait_inhibit(n);
      dev_frame(11, 1'b1, bits);
      check_output("t2_byte", bits[7:0], p_data[i]);
      check_output("t2_parity", bits[8], p_par[i]);
      wait_done(mark, 200, "t2_done", n);
      check_output("t2_err", last_err, 0);
      repeat (2) @(negedge clk);
    end

    // 3: device never clocks -> start timeout
    $display("[TB] step 3: start timeout");
    mark = done_count;
    apply_stimulus(PS2_CMD_RESET);
    wait_inhibit(n);
    wait_done(mark, 1000, "t3_done", n);
    check_output("t3_latency", (n >= 400 && n <= 410), 1);
    check_output("t3_err", last_err, 2);
    check_output("t3_data_rel", ps2data_low, 0);
    repeat (2) @(negedge clk);

    // 4a: no ack on the 11th fall
    $display("[TB] step 4: no ack and packet timeout");
    mark = done_count;
    apply_stimulus(8'hA5);
    wait_inhibit(n);
    dev_frame(11, 1'b0, bits);
    wait_done(mark, 200, "t4a_done", n);
    check_output("t4a_err", last_err, 1);
    check_output("t4a_data_rel", ps2data_low, 0);
    repeat (2) @(negedge clk);

    // 4b: device stops after 5 falls -> packet timeout
    mark = done_count;
    apply_stimulus(8'h3C);
    wait_inhibit(n);
    dev_frame(5, 1'b0, bits);
    wait_done(mark, 6000, "t4b_done", n);
    check_output("t4b_err", last_err, 3);
    check_output("t4b_data_rel", ps2data_low, 0);
    repeat (2) @(negedge clk);

    // 5: reset in the middle of SEND after the 4th fall
    $display("[TB] step 5: reset mid-transfer");
    mark = done_count;
    apply_stimulus(8'h52);
    wait_inhibit(n);
    dev_frame(4, 1'b0, bits);
    check_output("t5_pre_data_low", ps2data_low, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("t5_clk_rel", ps2clk_low, 0);
    check_output("t5_data_rel", ps2data_low, 0);
    check_output("t5_ready", bus.tx_ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check_output("t5_no_done", done_count - mark, 0);
    mark = done_count;
    apply_stimulus(PS2_CMD_RESET);
    wait_inhibit(n);
    dev_frame(11, 1'b1, bits);
    check_output("t5_next_byte", bits[7:0], 8'hFF);
    wait_done(mark, 200, "t5_next_done", n);
    check_output("t5_next_err", last_err, 0);
    repeat (2) @(negedge clk);

    // 6: tx_valid held with changing tx_data -> bytes sent one after the other
    $display("[TB] step 6: held valid");
    mark = done_count;
    bus.tx_data  = 8'h12;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_data  = 8'h34;
    wait_inhibit(n);
    dev_frame(11, 1'b1, bits);
    check_output("t6_first_byte", bits[7:0], 8'h12);
    wait_done(mark, 200, "t6_first_done", n);
    mark = done_count;
    wait_inhibit(n);
    bus.tx_valid = 1'b0;
    check_output("t6_second_inhibit", n, 20);
    dev_frame(11, 1'b1, bits);
    check_output("t6_second_byte", bits[7:0], 8'h34);
    wait_done(mark, 200, "t6_second_done", n);
    check_output("t6_err", last_err, 0);
    repeat (5) @(negedge clk);
    check_output("t6_idle_ready", bus.tx_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
